// File: rtl/tcb_lite_pkg.sv
// rtl/tcb_lite_pkg.sv - shared types and helpers for TCB lite responders
package tcb_lite_pkg;

    // Backpressure FSM states of the memory responder.
    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

    // Width of the log2-size field for a bus of 'byt' bytes (never below one bit).
    function automatic int unsigned siz_width(input int unsigned byt);
        int unsigned w;
        w = $clog2($clog2(byt) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tcb_lite_lib_rsp_delay.sv
// rtl/tcb_lite_lib_rsp_delay.sv - DLY-stage response pipeline with held read data
module tcb_lite_lib_rsp_delay #(
    parameter int unsigned DAT = 32,
    parameter int unsigned DLY = 1
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_vld,
    input  logic [DAT-1:0] i_rdt,
    input  logic           i_err,
    output logic           o_vld,
    output logic [DAT-1:0] o_rdt,
    output logic           o_err
);

    // One pipeline stage; data only moves with a valid so rdt holds between responses.
    typedef struct packed {
        logic           vld;
        logic [DAT-1:0] rdt;
        logic           err;
    } stage_t;

    generate
        if (DLY == 0) begin : g_comb
            logic [DAT-1:0] r_hold;

            // Remember the last response so rdt holds while no transfer is present.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hold <= '0;
                end else if (i_vld) begin
                    r_hold <= i_rdt;
                end
            end

            assign o_vld = i_vld;
            assign o_rdt = i_vld ? i_rdt : r_hold;
            assign o_err = i_vld & i_err;
        end else begin : g_pipe
            stage_t r_stg [DLY];

            // Shift the valid chain every cycle; reset drops any in-flight response.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(DLY); i++) begin
                        r_stg[i] <= '0;
                    end
                end else begin
                    r_stg[0].vld <= i_vld;
                    if (i_vld) begin
                        r_stg[0].rdt <= i_rdt;
                        r_stg[0].err <= i_err;
                    end
                    for (int i = 1; i < int'(DLY); i++) begin
                        r_stg[i].vld <= r_stg[i-1].vld;
                        if (r_stg[i-1].vld) begin
                            r_stg[i].rdt <= r_stg[i-1].rdt;
                            r_stg[i].err <= r_stg[i-1].err;
                        end
                    end
                end
            end

            assign o_vld = r_stg[DLY-1].vld;
            assign o_rdt = r_stg[DLY-1].rdt;
            assign o_err = r_stg[DLY-1].vld & r_stg[DLY-1].err;
        end
    endgenerate

endmodule

// File: rtl/tcb_lite_lib_memory.sv
// rtl/tcb_lite_lib_memory.sv - TCB lite memory responder with delay and optional stall
module tcb_lite_lib_memory
    import tcb_lite_pkg::*;
#(
    parameter  int unsigned DAT = 32,
    parameter  int unsigned ADR = 32,
    parameter  int unsigned DLY = 1,
    parameter  int unsigned CTL = 1,
    parameter  int unsigned SIZ = 1024,
    parameter  int unsigned STL = 0,
    localparam int unsigned BYT = DAT / 8,
    localparam int unsigned SZW = siz_width(BYT)
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_vld,
    output logic           o_rdy,
    input  logic           i_lck,
    input  logic           i_ndn,
    input  logic           i_wen,
    input  logic           i_ren,
    input  logic [CTL-1:0] i_ctl,
    input  logic [ADR-1:0] i_adr,
    input  logic [SZW-1:0] i_siz,
    input  logic [BYT-1:0] i_byt,
    input  logic [DAT-1:0] i_wdt,
    output logic [DAT-1:0] o_rdt,
    output logic [CTL-1:0] o_sts,
    output logic           o_err
);

    localparam int unsigned MAW = $clog2(SIZ);
    localparam int unsigned LBW = $clog2(BYT);
    localparam int unsigned WRD = SIZ / BYT;
    localparam int unsigned CNW = (STL > 0) ? $clog2(STL + 1) : 1;

    logic [DAT-1:0]     r_mem [WRD];
    stall_state_t       r_state;
    stall_state_t       w_state_nxt;
    logic [CNW-1:0]     r_cnt;
    logic [CNW-1:0]     w_cnt_nxt;

    logic               w_trn;
    logic               w_oor;
    logic               w_mis;
    logic               w_err;
    logic [MAW-LBW-1:0] w_idx;
    logic [DAT-1:0]     w_word;
    logic [DAT-1:0]     w_bmask;
    logic [DAT-1:0]     w_rdt;
    logic               w_rsp_vld;
    logic               w_unused;

    assign o_rdy = (r_state == ST_READY);
    assign w_trn = i_vld & o_rdy;

    generate
        if (ADR > MAW) begin : g_oor
            assign w_oor = |i_adr[ADR-1:MAW];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    // Misaligned when any address bit below the transfer size is set.
    assign w_mis = |(i_adr & ~({ADR{1'b1}} << i_siz));
    assign w_err = w_oor | w_mis;

    assign w_idx  = i_adr[MAW-1:LBW];
    assign w_word = r_mem[w_idx];

    // Expand byte enables into a bit mask over the data word.
    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < int'(BYT); i++) begin
            w_bmask[8*i +: 8] = {8{i_byt[i]}};
        end
    end

    // Asynchronous read of the old word gives read-before-write within one transfer.
    assign w_rdt = (i_ren & ~w_err) ? (w_word & w_bmask) : '0;

    // Lane-wise write of committed transfers; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_trn & i_wen & ~w_err & ~rst) begin
            for (int i = 0; i < int'(BYT); i++) begin
                if (i_byt[i]) begin
                    r_mem[w_idx][8*i +: 8] <= i_wdt[8*i +: 8];
                end
            end
        end
    end

    // Stall FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Enter STALL after an unlocked transfer; leave when the counter reaches one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_READY: begin
                if (i_vld && !i_lck && (STL > 0)) begin
                    w_state_nxt = ST_STALL;
                    w_cnt_nxt   = CNW'(STL);
                end
            end
            ST_STALL: begin
                w_cnt_nxt = r_cnt - CNW'(1);
                if (r_cnt <= CNW'(1)) begin
                    w_state_nxt = ST_READY;
                end
            end
            default: begin
                w_state_nxt = ST_READY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    tcb_lite_lib_rsp_delay #(
        .DAT (DAT),
        .DLY (DLY)
    ) u_rsp_delay (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_trn),
        .i_rdt (w_rdt),
        .i_err (w_err),
        .o_vld (w_rsp_vld),
        .o_rdt (o_rdt),
        .o_err (o_err)
    );

    assign o_sts    = '0;
    assign w_unused = &{1'b0, i_ndn, i_ctl, w_rsp_vld};

endmodule

// File: tb/tb_tcb_lite_lib_memory.sv
// tb/tb_tcb_lite_lib_memory.sv - directed self-checking bench for tcb_lite_lib_memory
module tb_tcb_lite_lib_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        lck = 1'b0;
    logic        ndn = 1'b0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [0:0]  ctl = 1'b0;
    logic [31:0] adr = '0;
    logic [1:0]  siz = '0;
    logic [3:0]  byt = '0;
    logic [31:0] wdt = '0;

    logic        rdy1, rdys, rdy0, rdy3;
    logic [31:0] rdt1, rdts, rdt0, rdt3;
    logic [0:0]  sts1, stss, sts0, sts3;
    logic        err1, errs, err0, err3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tcb_lite_lib_memory #(.DAT(32), .ADR(32), .DLY(1), .CTL(1), .SIZ(1024), .STL(0)) u_d1 (
        .clk(clk), .rst(rst), .i_vld(vld), .o_rdy(rdy1), .i_lck(lck), .i_ndn(ndn),
        .i_wen(wen), .i_ren(ren), .i_ctl(ctl), .i_adr(adr), .i_siz(siz), .i_byt(byt),
        .i_wdt(wdt), .o_rdt(rdt1), .o_sts(sts1), .o_err(err1));

    tcb_lite_lib_memory #(.DAT(32), .ADR(32), .DLY(1), .CTL(1), .SIZ(1024), .STL(2)) u_ds (
        .clk(clk), .rst(rst), .i_vld(vld), .o_rdy(rdys), .i_lck(lck), .i_ndn(ndn),
        .i_wen(wen), .i_ren(ren), .i_ctl(ctl), .i_adr(adr), .i_siz(siz), .i_byt(byt),
        .i_wdt(wdt), .o_rdt(rdts), .o_sts(stss), .o_err(errs));

    tcb_lite_lib_memory #(.DAT(32), .ADR(32), .DLY(0), .CTL(1), .SIZ(1024), .STL(0)) u_d0 (
        .clk(clk), .rst(rst), .i_vld(vld), .o_rdy(rdy0), .i_lck(lck), .i_ndn(ndn),
        .i_wen(wen), .i_ren(ren), .i_ctl(ctl), .i_adr(adr), .i_siz(siz), .i_byt(byt),
        .i_wdt(wdt), .o_rdt(rdt0), .o_sts(sts0), .o_err(err0));

    tcb_lite_lib_memory #(.DAT(32), .ADR(32), .DLY(3), .CTL(1), .SIZ(1024), .STL(0)) u_d3 (
        .clk(clk), .rst(rst), .i_vld(vld), .o_rdy(rdy3), .i_lck(lck), .i_ndn(ndn),
        .i_wen(wen), .i_ren(ren), .i_ctl(ctl), .i_adr(adr), .i_siz(siz), .i_byt(byt),
        .i_wdt(wdt), .o_rdt(rdt3), .o_sts(sts3), .o_err(err3));

    task automatic drive(input logic w, input logic r, input logic l, input logic [31:0] a,
                         input logic [1:0] s, input logic [3:0] b, input logic [31:0] d);
        vld = 1'b1; wen = w; ren = r; lck = l; adr = a; siz = s; byt = b; wdt = d;
    endtask

    task automatic idle();
        vld = 1'b0; wen = 1'b0; ren = 1'b0; lck = 1'b0;
    endtask

    task automatic xfer();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (3) xfer();
        @(negedge clk);
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_rdy1 got %b want 1", rdy1); end
        total++; if (rdys !== 1'b1) begin bad++; $display("FAIL reset_rdys got %b want 1", rdys); end
        total++; if (rdt1 !== 32'h0) begin bad++; $display("FAIL reset_rdt1 got %h want 0", rdt1); end
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL reset_err1 got %b want 0", err1); end
        total++; if (rdt3 !== 32'h0 || err3 !== 1'b0) begin bad++; $display("FAIL reset_d3 got rdt=%h err=%b want 0/0", rdt3, err3); end
        total++; if (rdt0 !== 32'h0 || err0 !== 1'b0) begin bad++; $display("FAIL reset_d0 got rdt=%h err=%b want 0/0", rdt0, err0); end
        total++; if (sts1 !== 1'b0) begin bad++; $display("FAIL reset_sts got %b want 0", sts1); end
        rst = 1'b0;
        xfer();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b0, 1'b0, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF);
        xfer();
        drive(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);
        xfer();
        idle();
        @(negedge clk);
        total++; if (rdt1 !== 32'hDEADBEEF) begin bad++; $display("FAIL full_rd got %h want deadbeef", rdt1); end
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL full_rd_err got %b want 0", err1); end
    endtask

    task automatic test_partial();
        drive(1'b1, 1'b0, 1'b0, 32'h10, 2'd2, 4'b0010, 32'h0000AB00);
        xfer();
        drive(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);
        xfer();
        idle();
        @(negedge clk);
        total++; if (rdt1 !== 32'hDEADABEF) begin bad++; $display("FAIL partial_rd got %h want deadabef", rdt1); end
        drive(1'b0, 1'b1, 1'b0, 32'h11, 2'd0, 4'b0010, 32'h0);
        xfer();
        idle();
        @(negedge clk);
        total++; if (rdt1 !== 32'h0000AB00 || err1 !== 1'b0) begin bad++; $display("FAIL byte_rd got rdt=%h err=%b want 0000ab00/0", rdt1, err1); end
    endtask

    task automatic test_error();
        drive(1'b1, 1'b0, 1'b0, 32'h12, 2'd2, 4'hF, 32'hFFFFFFFF);
        xfer();
        idle();
        @(negedge clk);
        total++; if (err1 !== 1'b1 || rdt1 !== 32'h0) begin bad++; $display("FAIL mis_wr got err=%b rdt=%h want 1/0", err1, rdt1); end
        drive(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);
        xfer();
        idle();
        @(negedge clk);
        total++; if (rdt1 !== 32'hDEADABEF || err1 !== 1'b0) begin bad++; $display("FAIL after_mis got rdt=%h err=%b want deadabef/0", rdt1, err1); end
        drive(1'b0, 1'b1, 1'b0, 32'h400, 2'd2, 4'hF, 32'h0);
        xfer();
        idle();
        @(negedge clk);
        total++; if (err1 !== 1'b1 || rdt1 !== 32'h0) begin bad++; $display("FAIL oor_rd got err=%b rdt=%h want 1/0", err1, rdt1); end
        drive(1'b0, 1'b1, 1'b0, 32'h3FC, 2'd2, 4'hF, 32'h0);
        xfer();
        idle();
        @(negedge clk);
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL top_word_err got %b want 0", err1); end
        drive(1'b0, 1'b1, 1'b0, 32'h11, 2'd1, 4'b0011, 32'h0);
        xfer();
        idle();
        @(negedge clk);
        total++; if (err1 !== 1'b1) begin bad++; $display("FAIL mis_half got %b want 1", err1); end
        @(negedge clk);
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL err_no_rsp got %b want 0", err1); end
    endtask

    task automatic test_stall();
        int pat [7] = '{1, 0, 0, 1, 0, 0, 1};
        int ntr;
        idle();
        repeat (4) xfer();
        ntr = 0;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 7) begin
                total++;
                if (rdys !== pat[i][0]) begin bad++; $display("FAIL stall_rdy[%0d] got %b want %0d", i, rdys, pat[i]); end
            end
            if (vld && rdys) ntr++;
            xfer();
        end
        idle();
        total++; if (ntr != 4) begin bad++; $display("FAIL stall_cnt got %0d want 4", ntr); end
        repeat (3) xfer();
        ntr = 0;
        drive(1'b0, 1'b1, 1'b1, 32'h10, 2'd2, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (rdys !== 1'b1) begin bad++; $display("FAIL lck_rdy[%0d] got %b want 1", i, rdys); end
            if (vld && rdys) ntr++;
            xfer();
        end
        idle();
        total++; if (ntr != 4) begin bad++; $display("FAIL lck_cnt got %0d want 4", ntr); end
        @(negedge clk);
        total++; if (rdys !== 1'b1) begin bad++; $display("FAIL lck_after got %b want 1", rdys); end
    endtask

    task automatic test_rbw();
        drive(1'b1, 1'b0, 1'b0, 32'h20, 2'd2, 4'hF, 32'h11111111);
        xfer();
        drive(1'b1, 1'b1, 1'b0, 32'h20, 2'd2, 4'hF, 32'h22222222);
        xfer();
        idle();
        @(negedge clk);
        total++; if (rdt1 !== 32'h11111111) begin bad++; $display("FAIL rbw_old got %h want 11111111", rdt1); end
        drive(1'b0, 1'b1, 1'b0, 32'h20, 2'd2, 4'hF, 32'h0);
        #1;
        total++; if (rdt0 !== 32'h22222222 || err0 !== 1'b0) begin bad++; $display("FAIL d0_comb got rdt=%h err=%b want 22222222/0", rdt0, err0); end
        xfer();
        idle();
        @(negedge clk);
        total++; if (rdt1 !== 32'h22222222) begin bad++; $display("FAIL rbw_new got %h want 22222222", rdt1); end
        total++; if (rdt0 !== 32'h22222222 || err0 !== 1'b0) begin bad++; $display("FAIL d0_hold got rdt=%h err=%b want 22222222/0", rdt0, err0); end
    endtask

    task automatic test_latency();
        drive(1'b0, 1'b1, 1'b0, 32'h400, 2'd2, 4'hF, 32'h0);
        #1;
        total++; if (err0 !== 1'b1) begin bad++; $display("FAIL d0_err got %b want 1", err0); end
        xfer();
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (err3 !== (k == 2)) begin bad++; $display("FAIL d3_err[%0d] got %b want %0d", k, err3, (k == 2)); end
        end
        drive(1'b0, 1'b1, 1'b0, 32'h20, 2'd2, 4'hF, 32'h0);
        xfer();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (rdt3 !== ((k < 2) ? 32'h0 : 32'h22222222)) begin
                bad++; $display("FAIL d3_rdt[%0d] got %h want %h", k, rdt3, ((k < 2) ? 32'h0 : 32'h22222222));
            end
        end
        repeat (3) xfer();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);
        xfer();
        idle();
        rst = 1'b1;
        xfer();
        rst = 1'b0;
        @(negedge clk);
        total++; if (rdys !== 1'b1 || rdy1 !== 1'b1) begin bad++; $display("FAIL mid_rdy got s=%b d1=%b want 1/1", rdys, rdy1); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rdt3 !== 32'h0 || err3 !== 1'b0) begin bad++; $display("FAIL mid_drop[%0d] got rdt=%h err=%b want 0/0", k, rdt3, err3); end
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);
        xfer();
        idle();
        @(negedge clk);
        total++; if (rdt1 !== 32'hDEADABEF) begin bad++; $display("FAIL mid_keep got %h want deadabef", rdt1); end
        @(negedge clk);
        @(negedge clk);
        total++; if (rdt3 !== 32'hDEADABEF || err3 !== 1'b0) begin bad++; $display("FAIL mid_keep3 got rdt=%h err=%b want deadabef/0", rdt3, err3); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_error();
        test_stall();
        test_rbw();
        test_latency();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
